// File: rtl/jtag_pkg.sv
// Shared types and constants for the JTAG-to-AHB-Lite debug bridge.
package jtag_pkg;

  localparam int unsigned REGISTER_SIZE = 32;
  localparam int unsigned IR_SIZE       = 4;
  localparam int unsigned STATE_SIZE    = 4;

  // Reset value of the IDCODE register; bit 0 must be 1.
  localparam logic [REGISTER_SIZE-1:0] IDCODE_DEFAULT = 32'h1000_0001;

  // Instruction opcodes as they sit in the IR after shifting.
  localparam logic [IR_SIZE-1:0] OP_BYPASS = 4'b0000;
  localparam logic [IR_SIZE-1:0] OP_IDCODE = 4'b1000;
  localparam logic [IR_SIZE-1:0] OP_ADDR   = 4'b0100;
  localparam logic [IR_SIZE-1:0] OP_WDATA  = 4'b1100;
  localparam logic [IR_SIZE-1:0] OP_RDATA  = 4'b0010;

  // Value loaded into the IR shift register on Capture-IR.
  localparam logic [IR_SIZE-1:0] IR_CAPTURE = 4'b0001;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // Standard 1149.1 TAP state encoding.
  typedef enum logic [STATE_SIZE-1:0] {
    TapExit2Dr    = 4'h0,
    TapExit1Dr    = 4'h1,
    TapShiftDr    = 4'h2,
    TapPauseDr    = 4'h3,
    TapSelectIr   = 4'h4,
    TapUpdateDr   = 4'h5,
    TapCaptureDr  = 4'h6,
    TapSelectDr   = 4'h7,
    TapExit2Ir    = 4'h8,
    TapExit1Ir    = 4'h9,
    TapShiftIr    = 4'hA,
    TapPauseIr    = 4'hB,
    TapRunIdle    = 4'hC,
    TapUpdateIr   = 4'hD,
    TapCaptureIr  = 4'hE,
    TapTestLogicReset = 4'hF
  } tap_state_e;

  typedef enum logic [1:0] {
    BusIdle = 2'b00,
    BusAddr = 2'b01,
    BusData = 2'b10
  } bus_state_e;

  typedef enum logic [2:0] {
    InstrBypass,
    InstrIdcode,
    InstrAddr,
    InstrWdata,
    InstrRdata
  } instr_e;

  // Unknown opcodes fall back to BYPASS.
  function automatic instr_e decode_instr(input logic [IR_SIZE-1:0] op);
    instr_e res;
    case (op)
      OP_IDCODE: res = InstrIdcode;
      OP_ADDR:   res = InstrAddr;
      OP_WDATA:  res = InstrWdata;
      OP_RDATA:  res = InstrRdata;
      default:   res = InstrBypass;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/jtag_if.sv
// AHB-Lite master/slave signal bundle used by the debug bridge.
interface jtag_if
  import jtag_pkg::*;
();

  logic                     HREADY;
  logic                     HRESP;
  logic [REGISTER_SIZE-1:0] HRDATA;
  logic [REGISTER_SIZE-1:0] HADDR;
  logic                     HWRITE;
  logic [1:0]               HTRANS;
  logic [REGISTER_SIZE-1:0] HWDATA;

  modport master (
    input  HREADY,
    input  HRESP,
    input  HRDATA,
    output HADDR,
    output HWRITE,
    output HTRANS,
    output HWDATA
  );

  modport slave (
    output HREADY,
    output HRESP,
    output HRDATA,
    input  HADDR,
    input  HWRITE,
    input  HTRANS,
    input  HWDATA
  );

endinterface

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP state machine: one transition per rising TCK, steered by TMS.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       rst,
  input  logic       tms,
  output tap_state_e state
);

  // Standard TAP transition table; reset parks in Test-Logic-Reset.
  always_ff @(posedge tck) begin
    if (rst) begin
      state <= TapTestLogicReset;
    end else begin
      case (state)
        TapTestLogicReset: state <= tms ? TapTestLogicReset : TapRunIdle;
        TapRunIdle:        state <= tms ? TapSelectDr : TapRunIdle;
        TapSelectDr:       state <= tms ? TapSelectIr : TapCaptureDr;
        TapCaptureDr:      state <= tms ? TapExit1Dr : TapShiftDr;
        TapShiftDr:        state <= tms ? TapExit1Dr : TapShiftDr;
        TapExit1Dr:        state <= tms ? TapUpdateDr : TapPauseDr;
        TapPauseDr:        state <= tms ? TapExit2Dr : TapPauseDr;
        TapExit2Dr:        state <= tms ? TapUpdateDr : TapShiftDr;
        TapUpdateDr:       state <= tms ? TapSelectDr : TapRunIdle;
        TapSelectIr:       state <= tms ? TapTestLogicReset : TapCaptureIr;
        TapCaptureIr:      state <= tms ? TapExit1Ir : TapShiftIr;
        TapShiftIr:        state <= tms ? TapExit1Ir : TapShiftIr;
        TapExit1Ir:        state <= tms ? TapUpdateIr : TapPauseIr;
        TapPauseIr:        state <= tms ? TapExit2Ir : TapPauseIr;
        TapExit2Ir:        state <= tms ? TapUpdateIr : TapShiftIr;
        TapUpdateIr:       state <= tms ? TapSelectDr : TapRunIdle;
        default:           state <= TapTestLogicReset;
      endcase
    end
  end

endmodule

// File: rtl/jtag.sv
// JTAG TAP to AHB-Lite bridge: IR/DR scan datapath plus a single-outstanding bus master.
module jtag
  import jtag_pkg::*;
#(
  // Bit 0 must stay 1 so hosts can tell IDCODE from BYPASS.
  parameter logic [REGISTER_SIZE-1:0] IDCODE_VALUE = IDCODE_DEFAULT
) (
  input  logic   TCK,
  input  logic   RST,
  input  logic   TMS,
  input  logic   TDI,
  output logic   TDO,
  jtag_if.master bus
);

  tap_state_e               state;
  instr_e                   instr;
  logic [IR_SIZE-1:0]       ir_q;
  logic [IR_SIZE-1:0]       ir_sr_q;
  logic [REGISTER_SIZE-1:0] dr_sr_q;
  logic [REGISTER_SIZE-1:0] capture_val;
  logic                     bypass_q;
  logic [REGISTER_SIZE-1:0] addr_q;
  logic [REGISTER_SIZE-1:0] wdata_q;
  logic [REGISTER_SIZE-1:0] rdata_q;
  logic                     write_q;
  bus_state_e               bus_q;

  jtag_tap_fsm u_tap (
    .tck   (TCK),
    .rst   (RST),
    .tms   (TMS),
    .state (state)
  );

  assign instr = decode_instr(ir_q);

  // Select the register image loaded into the DR shifter on Capture-DR.
  always_comb begin
    capture_val = '0;
    case (instr)
      InstrIdcode: capture_val = IDCODE_VALUE;
      InstrAddr:   capture_val = addr_q;
      InstrWdata:  capture_val = wdata_q;
      InstrRdata:  capture_val = rdata_q;
      default:     capture_val = '0;
    endcase
  end

  // IR and DR shift paths, driven by the current TAP state.
  always_ff @(posedge TCK) begin
    if (RST) begin
      ir_q     <= OP_IDCODE;
      ir_sr_q  <= '0;
      dr_sr_q  <= '0;
      bypass_q <= 1'b0;
    end else begin
      case (state)
        TapTestLogicReset: ir_q <= OP_IDCODE;
        TapCaptureIr:      ir_sr_q <= IR_CAPTURE;
        TapShiftIr:        ir_sr_q <= {TDI, ir_sr_q[IR_SIZE-1:1]};
        TapUpdateIr:       ir_q <= ir_sr_q;
        TapCaptureDr: begin
          dr_sr_q  <= capture_val;
          bypass_q <= 1'b0;
        end
        TapShiftDr: begin
          if (instr == InstrBypass) begin
            bypass_q <= TDI;
          end else begin
            dr_sr_q <= {TDI, dr_sr_q[REGISTER_SIZE-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  // Update-DR effects and the IDLE -> ADDR -> DATA bus sequencer. Updates that
  // arrive while a transfer is in flight are dropped so HADDR/HWDATA stay stable.
  always_ff @(posedge TCK) begin
    if (RST) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      write_q <= 1'b0;
      bus_q   <= BusIdle;
    end else begin
      case (bus_q)
        BusIdle: begin
          if (state == TapUpdateDr) begin
            case (instr)
              InstrAddr: addr_q <= dr_sr_q;
              InstrWdata: begin
                wdata_q <= dr_sr_q;
                write_q <= 1'b1;
                bus_q   <= BusAddr;
              end
              InstrRdata: begin
                write_q <= 1'b0;
                bus_q   <= BusAddr;
              end
              default: ;
            endcase
          end
        end
        BusAddr: begin
          if (bus.HREADY) begin
            bus_q <= BusData;
          end
        end
        BusData: begin
          if (bus.HREADY) begin
            if (!write_q && !bus.HRESP) begin
              rdata_q <= bus.HRDATA;
            end
            bus_q <= BusIdle;
          end
        end
        default: bus_q <= BusIdle;
      endcase
    end
  end

  assign bus.HADDR  = addr_q;
  assign bus.HWDATA = wdata_q;
  assign bus.HTRANS = (bus_q == BusAddr) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.HWRITE = (bus_q == BusAddr) && write_q;

  // TDO exposes bit 0 of whichever shifter is active; quiet otherwise.
  always_comb begin
    TDO = 1'b0;
    case (state)
      TapShiftDr: TDO = (instr == InstrBypass) ? bypass_q : dr_sr_q[0];
      TapShiftIr: TDO = ir_sr_q[0];
      default:    TDO = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_jtag.sv
// Self-checking bench for the JTAG-to-AHB bridge: vector table, directed corners, random ops.
module tb_jtag;

  localparam logic [3:0]  C_BYPASS = 4'b0000;
  localparam logic [3:0]  C_IDCODE = 4'b1000;
  localparam logic [3:0]  C_ADDR   = 4'b0100;
  localparam logic [3:0]  C_WDATA  = 4'b1100;
  localparam logic [3:0]  C_RDATA  = 4'b0010;
  localparam logic [31:0] C_IDVAL  = 32'h1000_0001;

  logic TCK = 1'b0;
  logic RST = 1'b1;
  logic TMS = 1'b1;
  logic TDI = 1'b0;
  logic TDO;

  jtag_if bus_if ();

  jtag dut (
    .TCK (TCK),
    .RST (RST),
    .TMS (TMS),
    .TDI (TDI),
    .TDO (TDO),
    .bus (bus_if)
  );

  always #5 TCK = ~TCK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One TCK: drive on the falling edge, sample TDO shortly after, return at rising edge.
  task automatic step(input logic tms, input logic tdi, output logic tdo);
    @(negedge TCK);
    TMS = tms;
    TDI = tdi;
    #1 tdo = TDO;
    @(posedge TCK);
  endtask

  task automatic idle(input int n);
    logic d;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, d);
  endtask

  // From Run-Test/Idle, load an instruction and return to Run-Test/Idle.
  task automatic scan_ir(input logic [3:0] op, output logic [3:0] cap);
    logic d;
    step(1'b1, 1'b0, d);
    step(1'b1, 1'b0, d);
    step(1'b0, 1'b0, d);
    step(1'b0, 1'b0, d);
    for (int i = 0; i < 4; i++) begin
      step((i == 3), op[i], d);
      cap[i] = d;
    end
    step(1'b1, 1'b0, d);
    step(1'b0, 1'b0, d);
  endtask

  // From Run-Test/Idle, shift n bits LSB first; returns on the Update-DR edge.
  task automatic scan_dr(input int n, input logic [31:0] din, output logic [31:0] dout);
    logic d;
    dout = '0;
    step(1'b1, 1'b0, d);
    step(1'b0, 1'b0, d);
    step(1'b0, 1'b0, d);
    for (int i = 0; i < n; i++) begin
      step((i == n - 1), din[i], d);
      dout[i] = d;
    end
    step(1'b1, 1'b0, d);
    step(1'b0, 1'b0, d);
  endtask

  // Bus monitor: records each accepted address phase plus the following data-phase HWDATA.
  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } xfer_t;
  xfer_t got_q[$];
  xfer_t exp_q[$];
  logic        mon_pend = 1'b0;
  logic        mon_w;
  logic [31:0] mon_a;

  always @(negedge TCK) begin
    #2;
    if (mon_pend) begin
      got_q.push_back('{w: mon_w, a: mon_a, d: bus_if.HWDATA});
      mon_pend = 1'b0;
    end
    if (bus_if.HTRANS == 2'b10 && bus_if.HREADY === 1'b1) begin
      mon_pend = 1'b1;
      mon_w    = bus_if.HWRITE;
      mon_a    = bus_if.HADDR;
    end
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] din;
    logic [31:0] exp_dout;
    logic [31:0] exp_haddr;
  } vec_t;
  vec_t vecs[6];

  logic [3:0]  cap;
  logic [31:0] dout;
  logic        d1;
  logic [3:0]  byp_ops[$];
  logic [31:0] m_addr, m_wdata, m_rdata, v, hr;
  logic        he;
  logic [3:0]  bop;
  int          kind;

  initial begin
    bus_if.HREADY = 1'b1;
    bus_if.HRESP  = 1'b0;
    bus_if.HRDATA = '0;

    // Reset state.
    @(posedge TCK);
    @(posedge TCK);
    #1;
    check("reset_tdo", TDO, 0);
    check("reset_htrans", bus_if.HTRANS, 0);
    check("reset_hwrite", bus_if.HWRITE, 0);
    check("reset_haddr", bus_if.HADDR, 0);
    check("reset_hwdata", bus_if.HWDATA, 0);
    @(negedge TCK);
    RST = 1'b0;
    step(1'b0, 1'b0, d1);
    scan_dr(32, 32'h0, dout);
    check("reset_idcode_scan", dout, C_IDVAL);

    // Any state + six TMS=1 lands in TLR, which restores IDCODE.
    scan_ir(C_ADDR, cap);
    for (int i = 0; i < 9; i++) step(1'($urandom_range(0, 1)), 1'b0, d1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, d1);
    step(1'b0, 1'b0, d1);
    scan_dr(32, 32'h0, dout);
    check("tlr_idcode_scan", dout, C_IDVAL);

    // Vector table; registers start at zero after reset.
    vecs[0] = '{op: C_ADDR,   din: 32'h89ab_cdef, exp_dout: 32'h0,          exp_haddr: 32'h89ab_cdef};
    vecs[1] = '{op: C_ADDR,   din: 32'h0000_0100, exp_dout: 32'h89ab_cdef, exp_haddr: 32'h100};
    vecs[2] = '{op: C_WDATA,  din: 32'h1234_5678, exp_dout: 32'h0,          exp_haddr: 32'h100};
    vecs[3] = '{op: C_WDATA,  din: 32'hcafe_f00d, exp_dout: 32'h1234_5678, exp_haddr: 32'h100};
    vecs[4] = '{op: C_IDCODE, din: 32'h0,         exp_dout: C_IDVAL,       exp_haddr: 32'h100};
    vecs[5] = '{op: C_RDATA,  din: 32'h0,         exp_dout: 32'h0,          exp_haddr: 32'h100};
    foreach (vecs[i]) begin
      scan_ir(vecs[i].op, cap);
      check($sformatf("vec%0d_ircap", i), cap, 4'b0001);
      scan_dr(32, vecs[i].din, dout);
      check($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
      idle(3);
      check($sformatf("vec%0d_haddr", i), bus_if.HADDR, vecs[i].exp_haddr);
    end

    // ADDR update alone moves HADDR without starting a transfer.
    scan_ir(C_ADDR, cap);
    scan_dr(32, 32'h89ab_cdef, dout);
    #1;
    check("addr_haddr", bus_if.HADDR, 32'h89ab_cdef);
    check("addr_htrans0", bus_if.HTRANS, 0);
    step(1'b0, 1'b0, d1);
    #1 check("addr_htrans1", bus_if.HTRANS, 0);
    scan_dr(32, 32'h100, dout);
    check("addr_readback", dout, 32'h89ab_cdef);

    // Write: exactly one NONSEQ cycle, then data phase, then idle.
    scan_ir(C_WDATA, cap);
    scan_dr(32, 32'h1234_5678, dout);
    #1;
    check("wr_htrans_a", bus_if.HTRANS, 2'b10);
    check("wr_hwrite_a", bus_if.HWRITE, 1);
    check("wr_haddr_a", bus_if.HADDR, 32'h100);
    step(1'b0, 1'b0, d1);
    #1;
    check("wr_htrans_d", bus_if.HTRANS, 0);
    check("wr_hwdata_d", bus_if.HWDATA, 32'h1234_5678);
    step(1'b0, 1'b0, d1);
    #1 check("wr_htrans_i", bus_if.HTRANS, 0);

    // Read: OKAY latches HRDATA, ERROR leaves it unchanged.
    bus_if.HRDATA = 32'h0000_f00f;
    scan_ir(C_RDATA, cap);
    scan_dr(32, 32'h0, dout);
    #1;
    check("rd_htrans_a", bus_if.HTRANS, 2'b10);
    check("rd_hwrite_a", bus_if.HWRITE, 0);
    idle(3);
    scan_dr(32, 32'h0, dout);
    check("rd_value", dout, 32'h0000_f00f);
    idle(3);
    bus_if.HRESP  = 1'b1;
    bus_if.HRDATA = 32'hdead_0000;
    scan_dr(32, 32'h0, dout);
    idle(3);
    scan_dr(32, 32'h0, dout);
    check("rd_err_unchanged", dout, 32'h0000_f00f);
    idle(3);
    bus_if.HRESP = 1'b0;

    // BYPASS and an undefined opcode both delay TDI by one TCK.
    scan_ir(C_BYPASS, cap);
    scan_dr(4, 32'b1101, dout);
    check("bypass_0000", dout, 32'b1010);
    scan_ir(4'b1111, cap);
    scan_dr(4, 32'b1101, dout);
    check("bypass_1111", dout, 32'b1010);

    // Reset while an address phase is stalled by HREADY=0.
    scan_ir(C_WDATA, cap);
    @(negedge TCK);
    bus_if.HREADY = 1'b0;
    scan_dr(32, 32'h5555_aaaa, dout);
    step(1'b0, 1'b0, d1);
    #1 check("stall_htrans", bus_if.HTRANS, 2'b10);
    @(negedge TCK);
    RST = 1'b1;
    @(posedge TCK);
    #1;
    check("rst_bus_htrans", bus_if.HTRANS, 0);
    check("rst_bus_hwrite", bus_if.HWRITE, 0);
    check("rst_bus_haddr", bus_if.HADDR, 0);
    check("rst_bus_hwdata", bus_if.HWDATA, 0);
    @(negedge TCK);
    RST = 1'b0;
    bus_if.HREADY = 1'b1;
    step(1'b0, 1'b0, d1);

    // Reset in the middle of Shift-DR.
    scan_ir(C_ADDR, cap);
    step(1'b1, 1'b0, d1);
    step(1'b0, 1'b0, d1);
    step(1'b0, 1'b0, d1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, d1);
    @(negedge TCK);
    RST = 1'b1;
    @(posedge TCK);
    #1 check("rst_shift_tdo", TDO, 0);
    @(negedge TCK);
    RST = 1'b0;
    step(1'b0, 1'b0, d1);
    scan_dr(32, 32'h0, dout);
    check("rst_shift_idcode", dout, C_IDVAL);

    // Random operations against a register-level model.
    for (int c = 0; c < 16; c++) begin
      if (!(c == 4'b1000 || c == 4'b0100 || c == 4'b1100 || c == 4'b0010))
        byp_ops.push_back(4'(c));
    end
    m_addr  = '0;
    m_wdata = '0;
    m_rdata = '0;
    idle(3);
    got_q.delete();
    for (int k = 0; k < 30; k++) begin
      kind = $urandom_range(0, 4);
      v    = $urandom;
      case (kind)
        0: begin
          scan_ir(C_ADDR, cap);
          scan_dr(32, v, dout);
          check("rnd_addr", dout, m_addr);
          m_addr = v;
        end
        1: begin
          scan_ir(C_WDATA, cap);
          scan_dr(32, v, dout);
          check("rnd_wdata", dout, m_wdata);
          m_wdata = v;
          exp_q.push_back('{w: 1'b1, a: m_addr, d: m_wdata});
        end
        2: begin
          hr = $urandom;
          he = 1'($urandom_range(0, 1));
          bus_if.HRDATA = hr;
          bus_if.HRESP  = he;
          scan_ir(C_RDATA, cap);
          scan_dr(32, v, dout);
          check("rnd_rdata", dout, m_rdata);
          exp_q.push_back('{w: 1'b0, a: m_addr, d: m_wdata});
          if (!he) m_rdata = hr;
        end
        3: begin
          scan_ir(C_IDCODE, cap);
          scan_dr(32, v, dout);
          check("rnd_idcode", dout, C_IDVAL);
        end
        default: begin
          bop = byp_ops[$urandom_range(0, byp_ops.size() - 1)];
          v   = v & 32'hff;
          scan_ir(bop, cap);
          scan_dr(8, v, dout);
          check("rnd_bypass", dout, (v << 1) & 32'hff);
        end
      endcase
      check("rnd_ircap", cap, 4'b0001);
      idle(3);
    end
    idle(3);
    check("bus_xfer_count", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("bus%0d_hwrite", i), got_q[i].w, exp_q[i].w);
      check($sformatf("bus%0d_haddr", i), got_q[i].a, exp_q[i].a);
      check($sformatf("bus%0d_hwdata", i), got_q[i].d, exp_q[i].d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
